// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared definitions for the writeback arbiter: register-address and data bus
// widths, the default number of writeback requesters, the registered
// write-port record and a helper that turns a register address into a one-hot
// scoreboard mask.
// Ports: none (package).
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

    localparam int REG_ADDR_BUS = 5;
    localparam int DATA_BUS     = 32;
    localparam int NREQ_DEFAULT = 4;
    localparam int NUM_REGS     = 1 << REG_ADDR_BUS;

    typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;
    typedef logic [DATA_BUS-1:0]     data_t;

    // One register-file write port as it sits in the output register.
    typedef struct packed {
        logic      we;
        reg_addr_t addr;
        data_t     data;
    } wr_port_t;

    // One-hot mask for register 'addr'; x0 never appears in the scoreboard.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic en, input reg_addr_t addr);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (en && (addr != '0)) begin
            m[addr] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational rotating two-grant picker. Starting at ptr_i and walking the
// requesters in increasing (wrapping) order, the first valid requester gets
// grant1_o and the second valid requester gets grant2_o, unless the second
// targets the same nonzero register as the first, in which case only the
// first is granted and the second retries later.
// Ports:
//   valid_i     [NREQ]        requester has a pending write
//   conflict_i  [NREQ][NREQ]  conflict_i[a][b]: a and b target the same nonzero reg
//   ptr_i       [PTR_W]       rotating priority start index
//   grant1_o    [NREQ]        one-hot first grant (or zero)
//   grant2_o    [NREQ]        one-hot second grant (or zero)
// -----------------------------------------------------------------------------
module rr_pick2
    import wb_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEFAULT,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]           valid_i,
    input  logic [NREQ-1:0][NREQ-1:0] conflict_i,
    input  logic [PTR_W-1:0]          ptr_i,
    output logic [NREQ-1:0]           grant1_o,
    output logic [NREQ-1:0]           grant2_o
);

    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] first;
    logic             found1;
    logic             found2;

    always_comb begin
        grant1_o = '0;
        grant2_o = '0;
        idx      = '0;
        first    = '0;
        found1   = 1'b0;
        found2   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PTR_W'((int'(ptr_i) + k) % NREQ);
            if (valid_i[idx]) begin
                if (!found1) begin
                    found1          = 1'b1;
                    first           = idx;
                    grant1_o[idx]   = 1'b1;
                end else if (!found2) begin
                    // The second candidate is consumed even when it conflicts,
                    // so a third requester never jumps ahead of it.
                    found2 = 1'b1;
                    if (!conflict_i[first][idx]) begin
                        grant2_o[idx] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Writeback arbiter for a two-write-port register file. Up to two requesters
// are granted per cycle in rotating priority; the granted writes are
// registered onto we1/waddr1/wdata1 and we2/waddr2/wdata2 one cycle after the
// grant. A 32-bit scoreboard (busy) tracks registers with a write in flight:
// set by the issue stage, cleared when the write is loaded onto a port.
// Handshake: a transfer happens in a cycle where req_valid[i] && req_ready[i];
// req_ready is combinational, and a requester holds addr/data stable while
// valid and not ready.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/addr/data      per-requester write request (addr 5b, data 32b)
//   req_ready                per-requester grant
//   we1/waddr1/wdata1        registered register-file write port 1
//   we2/waddr2/wdata2        registered register-file write port 2
//   iss_valid/iss_addr       issue stage marks a destination as in flight
//   busy                     scoreboard, busy[0] always 0
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*REG_ADDR_BUS-1:0] req_addr,
    input  logic [NREQ*DATA_BUS-1:0]     req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic                         we1,
    output logic [REG_ADDR_BUS-1:0]      waddr1,
    output logic [DATA_BUS-1:0]          wdata1,
    output logic                         we2,
    output logic [REG_ADDR_BUS-1:0]      waddr2,
    output logic [DATA_BUS-1:0]          wdata2,
    input  logic                         iss_valid,
    input  logic [REG_ADDR_BUS-1:0]      iss_addr,
    output logic [NUM_REGS-1:0]          busy
);

    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0]          rr_ptr_q;
    logic [PTR_W-1:0]          rr_ptr_d;
    wr_port_t                  wr1_q;
    wr_port_t                  wr1_d;
    wr_port_t                  wr2_q;
    wr_port_t                  wr2_d;
    logic [NUM_REGS-1:0]       busy_q;
    logic [NUM_REGS-1:0]       busy_d;
    logic [NREQ-1:0]           pick_valid;
    logic [NREQ-1:0]           grant1;
    logic [NREQ-1:0]           grant2;
    logic [NREQ-1:0][NREQ-1:0] conflict;

    // Pairwise same-destination detection; writes to x0 never conflict
    // because they are discarded anyway.
    always_comb begin
        conflict = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                conflict[i][j] = (req_addr[i*REG_ADDR_BUS +: REG_ADDR_BUS] ==
                                  req_addr[j*REG_ADDR_BUS +: REG_ADDR_BUS]) &&
                                 (req_addr[i*REG_ADDR_BUS +: REG_ADDR_BUS] != '0);
            end
        end
    end

    // Masking the picker input keeps req_ready low for the whole reset.
    assign pick_valid = req_valid & {NREQ{~rst}};

    rr_pick2 #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .valid_i    (pick_valid),
        .conflict_i (conflict),
        .ptr_i      (rr_ptr_q),
        .grant1_o   (grant1),
        .grant2_o   (grant2)
    );

    assign req_ready = grant1 | grant2;

    // Route grants to the ports and advance the pointer past the last grant.
    always_comb begin
        wr1_d    = '0;
        wr2_d    = '0;
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (grant1[i]) begin
                wr1_d.addr = req_addr[i*REG_ADDR_BUS +: REG_ADDR_BUS];
                wr1_d.data = req_data[i*DATA_BUS +: DATA_BUS];
                wr1_d.we   = (req_addr[i*REG_ADDR_BUS +: REG_ADDR_BUS] != '0);
                if (grant2 == '0) begin
                    rr_ptr_d = PTR_W'((i + 1) % NREQ);
                end
            end
            if (grant2[i]) begin
                wr2_d.addr = req_addr[i*REG_ADDR_BUS +: REG_ADDR_BUS];
                wr2_d.data = req_data[i*DATA_BUS +: DATA_BUS];
                wr2_d.we   = (req_addr[i*REG_ADDR_BUS +: REG_ADDR_BUS] != '0);
                rr_ptr_d   = PTR_W'((i + 1) % NREQ);
            end
        end
    end

    // Clear on the edge that loads the write, then OR in the new issue so a
    // same-edge set of the same register survives (newer write wins).
    always_comb begin
        busy_d = (busy_q & ~(reg_mask(wr1_d.we, wr1_d.addr) | reg_mask(wr2_d.we, wr2_d.addr)))
                 | reg_mask(iss_valid, iss_addr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            wr1_q    <= '0;
            wr2_q    <= '0;
            busy_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr1_q    <= wr1_d;
            wr2_q    <= wr2_d;
            busy_q   <= busy_d;
        end
    end

    assign we1    = wr1_q.we;
    assign waddr1 = wr1_q.addr;
    assign wdata1 = wr1_q.data;
    assign we2    = wr2_q.we;
    assign waddr2 = wr2_q.addr;
    assign wdata2 = wr2_q.data;
    assign busy   = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed scenarios followed by random traffic. A reference model (rotation
// order list, busy bit-vector, register-file array) predicts grants and pushes
// expected port writes into exp_q; a monitor pops and compares whenever the
// DUT asserts we1/we2 and also plays the register file committing on negedge.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int NREQ = 4;
    localparam int EW   = 16 + 1 + 5 + 32;  // {cycle, port, addr, data}

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*5-1:0]   req_addr;
    logic [NREQ*32-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                we1;
    logic [4:0]          waddr1;
    logic [31:0]         wdata1;
    logic                we2;
    logic [4:0]          waddr2;
    logic [31:0]         wdata2;
    logic                iss_valid;
    logic [4:0]          iss_addr;
    logic [31:0]         busy;

    wb_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .we1       (we1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .we2       (we2),
        .waddr2    (waddr2),
        .wdata2    (wdata2),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int             checks   = 0;
    int             failures = 0;
    int             cyc      = 0;
    logic [EW-1:0]  exp_q[$];
    logic [EW-1:0]  mwr_q[$];
    logic [31:0]    rf   [32];
    logic [31:0]    m_rf [32];
    logic           pend_v [NREQ];
    logic [4:0]     pend_a [NREQ];
    logic [31:0]    pend_d [NREQ];
    int             m_ptr;
    logic [31:0]    m_busy;
    logic [NREQ-1:0] last_ready;
    logic           last_we1;
    logic [EW-1:0]  mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = pend_v[i];
            req_addr[i*5 +: 5]  = pend_a[i];
            req_data[i*32 +: 32] = pend_d[i];
        end
    endtask

    // Negedge half: commit model writes, predict grants, compare, update model.
    task automatic half_neg();
        int              order[$];
        int              g1;
        int              g2;
        int              last;
        logic [NREQ-1:0] exp_rdy;
        logic [31:0]     clr;
        logic [31:0]     set;
        logic [EW-1:0]   w;
        @(negedge clk);
        #1;
        while (mwr_q.size() > 0 && mwr_q[0][EW-1 -: 16] == 16'(cyc)) begin
            w = mwr_q.pop_front();
            m_rf[w[36:32]] = w[31:0];
        end
        order.delete();
        for (int k = 0; k < NREQ; k++) begin
            if (pend_v[(m_ptr + k) % NREQ]) order.push_back((m_ptr + k) % NREQ);
        end
        g1 = -1;
        g2 = -1;
        if (order.size() > 0) g1 = order[0];
        if (order.size() > 1) begin
            g2 = order[1];
            if (pend_a[g2] == pend_a[g1] && pend_a[g1] != 5'd0) g2 = -1;
        end
        exp_rdy = '0;
        if (g1 >= 0) exp_rdy[g1] = 1'b1;
        if (g2 >= 0) exp_rdy[g2] = 1'b1;
        last_ready = req_ready;
        last_we1   = we1;
        check("req_ready", req_ready, exp_rdy);
        check("busy", busy, m_busy);
        clr = '0;
        if (g1 >= 0 && pend_a[g1] != 5'd0) begin
            w = {16'(cyc + 1), 1'b0, pend_a[g1], pend_d[g1]};
            exp_q.push_back(w);
            mwr_q.push_back(w);
            clr[pend_a[g1]] = 1'b1;
        end
        if (g2 >= 0 && pend_a[g2] != 5'd0) begin
            w = {16'(cyc + 1), 1'b1, pend_a[g2], pend_d[g2]};
            exp_q.push_back(w);
            mwr_q.push_back(w);
            clr[pend_a[g2]] = 1'b1;
        end
        set = '0;
        if (iss_valid && iss_addr != 5'd0) set[iss_addr] = 1'b1;
        m_busy = (m_busy & ~clr) | set;
        last = (g2 >= 0) ? g2 : g1;
        if (last >= 0) m_ptr = (last + 1) % NREQ;
        if (g1 >= 0) pend_v[g1] = 1'b0;
        if (g2 >= 0) pend_v[g2] = 1'b0;
    endtask

    task automatic half_pos();
        @(posedge clk);
        #1;
        cyc++;
        iss_valid = 1'b0;
    endtask

    task automatic step();
        drive();
        half_neg();
        half_pos();
    endtask

    task automatic new_req(input int i, input logic [4:0] a, input logic [31:0] d);
        pend_v[i] = 1'b1;
        pend_a[i] = a;
        pend_d[i] = d;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (we1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_port1_spurious: got addr %0h data %0h expected no write (cycle %0d)", waddr1, wdata1, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_port1", {16'(cyc), 1'b0, waddr1, wdata1}, mon_e);
            end
            rf[waddr1] = wdata1;
        end
        if (we2) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_port2_spurious: got addr %0h data %0h expected no write (cycle %0d)", waddr2, wdata2, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_port2", {16'(cyc), 1'b1, waddr2, wdata2}, mon_e);
            end
            rf[waddr2] = wdata2;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        iss_valid = 1'b1;
        iss_addr  = 5'd3;
        m_ptr     = 0;
        m_busy    = '0;
        for (int r = 0; r < 32; r++) begin
            rf[r]   = '0;
            m_rf[r] = '0;
        end
        for (int i = 0; i < NREQ; i++) new_req(i, 5'(i + 1), 32'h1000 + 32'(i));
        drive();

        // Reset state, with requests and an issue held active.
        @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_we1", we1, 1'b0);
        check("rst_we2", we2, 1'b0);
        check("rst_waddr1", waddr1, 5'd0);
        check("rst_wdata2", wdata2, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 32'd0);
        for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
        iss_valid = 1'b0;
        rst = 1'b0;

        // All four valid from ptr 0: pairs 0,1 / 2,3 / 0,1 / 2,3.
        for (int r = 0; r < 4; r++) begin
            if (r < 3) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!pend_v[i]) new_req(i, 5'(i + 1), $urandom);
                end
            end
            step();
            check("rr_pair", last_ready, (r % 2 == 0) ? 4'b0011 : 4'b1100);
        end

        // Same destination x5 from req0 and req2.
        new_req(0, 5'd5, 32'hAAAA0000);
        new_req(2, 5'd5, 32'hBBBB0000);
        step();
        check("x5_first_grant", last_ready, 4'b0001);
        step();
        check("x5_retry_grant", last_ready, 4'b0100);
        step();
        check("x5_final", rf[5], 32'hBBBB0000);

        // Write to x0 is granted but discarded.
        new_req(1, 5'd0, 32'hDEADBEEF);
        step();
        check("addr0_ready", last_ready[1], 1'b1);
        step();
        check("addr0_we1", last_we1, 1'b0);

        // Scoreboard set / clear on x7.
        iss_valid = 1'b1;
        iss_addr  = 5'd7;
        step();
        check("busy7_set", busy[7], 1'b1);
        new_req(0, 5'd7, 32'h77770001);
        step();
        check("busy7_we1", we1, 1'b1);
        check("busy7_clear", busy[7], 1'b0);
        iss_valid = 1'b1;
        iss_addr  = 5'd7;
        step();
        check("busy7_reissue", busy[7], 1'b1);
        new_req(3, 5'd7, 32'h77770002);
        iss_valid = 1'b1;
        iss_addr  = 5'd7;
        step();
        check("busy7_same_edge_we1", we1, 1'b1);
        check("busy7_set_wins", busy[7], 1'b1);

        // Reset between a grant and its output edge.
        iss_valid = 1'b1;
        iss_addr  = 5'd12;
        step();
        new_req(0, 5'd9, 32'h12345678);
        new_req(1, 5'd10, 32'h9ABCDEF0);
        drive();
        half_neg();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_we1", we1, 1'b0);
        check("midrst_we2", we2, 1'b0);
        check("midrst_busy", busy, 32'd0);
        check("midrst_ready", req_ready, 4'b0000);
        exp_q.delete();
        mwr_q.delete();
        m_busy = '0;
        m_ptr  = 0;
        for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
        drive();
        half_pos();
        #1;
        rst = 1'b0;
        step();
        step();
        check("midrst_x9", rf[9], 32'd0);
        check("midrst_x10", rf[10], 32'd0);

        // Single requester held valid for three cycles.
        for (int r = 0; r < 3; r++) begin
            new_req(2, 5'd11, $urandom);
            step();
            check("single_req2", last_ready, 4'b0100);
        end
        new_req(0, 5'd13, $urandom);
        new_req(1, 5'd14, $urandom);
        new_req(3, 5'd15, $urandom);
        step();
        check("ptr_after_single", last_ready, 4'b1001);

        // Random traffic; small address range provokes conflicts.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_v[i] && $urandom_range(0, 1) == 1) begin
                    new_req(i, 5'($urandom_range(0, 7)), $urandom);
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                iss_valid = 1'b1;
                iss_addr  = 5'($urandom_range(0, 7));
            end
            step();
        end

        // Drain outstanding requests, then let the last writes commit.
        for (int n = 0; n < 20; n++) step();
        check("drain_exp_q_empty", 64'(exp_q.size()), 64'd0);
        for (int r = 0; r < 32; r++) check("rf_final", {27'd0, 5'(r), rf[r]}, {27'd0, 5'(r), m_rf[r]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
